// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted burst-shift engine (busy/done handshake).
// Define SHIFT_NEG_EDGE_EN to clock every flop on the falling edge of clk.

module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pdin,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | execute mode directly, or accept a burst request
    // SHIFT | burst running, one captured op per ce edge
    // DONE  | single-cycle completion pulse, no op executed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_LD  = 3'b101;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op, op_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic             exec;
    logic [2:0]       exec_op;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op;
        exec      = 1'b0;
        exec_op   = mode;
        case (state)
            IDLE: begin
                if (ce) begin
                    if (start && (mode inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL})) begin
                        op_nxt    = mode;
                        cnt_nxt   = len;
                        state_nxt = (len != '0) ? SHIFT : DONE;
                    end else begin
                        exec = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (ce) begin
                    exec    = 1'b1;
                    exec_op = op;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_nxt  = q;
        so_nxt = so;
        if (exec) begin
            case (exec_op)
                OP_SHR: begin
                    q_nxt  = {si, q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                OP_SHL: begin
                    q_nxt  = {q[WIDTH-2:0], si};
                    so_nxt = q[WIDTH-1];
                end
                OP_ROR: begin
                    q_nxt  = {q[0], q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                OP_ROL: begin
                    q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
                    so_nxt = q[WIDTH-1];
                end
                OP_LD:   q_nxt = pdin;
                default: q_nxt = q;
            endcase
        end
    end

`ifdef SHIFT_NEG_EDGE_EN
    always_ff @(negedge clk) begin
`else
    always_ff @(posedge clk) begin
`endif
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            q     <= '0;
            so    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
            q     <= q_nxt;
            so    <= so_nxt;
        end
    end

    // Both flags decode the state flop directly, so they stay registered.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: serial shift in either direction, rotate, parallel load and hold, plus a counted burst-shift engine with busy/done handshake. Next-generation replacement for the fixed 4-bit serial-in/serial-out shifter; used as the serialiser/deserialiser front end of the datapath blocks. Clock-edge polarity is selectable at compile time.

## Interface
- WIDTH, 8, register width (≥2)
- CNT_W, $clog2(WIDTH+1), width of burst length field

- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ce  in  1  clock enable; no state or register change when low (except DONE→IDLE)
- mode  in  3  000 hold, 001 shift right, 010 shift left, 011 rotate right, 100 rotate left, 101 parallel load, 110/111 hold
- si  in  1  serial input
- pdin  in  WIDTH  parallel load data
- start  in  1  request counted burst of shift/rotate operations
- len  in  CNT_W  number of operations in burst
- q  out  WIDTH  register contents
- so  out  1  registered; bit shifted/rotated out by most recent shift/rotate op
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Shift right: q ← {si, q[WIDTH-1:1]}, so ← q[0]. Shift left: q ← {q[WIDTH-2:0], si}, so ← q[WIDTH-1].
- Rotate right/left: as shift, vacated bit filled from the bit shifted out; so ← that bit.
- Parallel load: q ← pdin; so unchanged. Hold/reserved: nothing changes.
- FSM states IDLE, SHIFT, DONE.
- IDLE: on ce=1 and start=0, execute mode directly. On ce=1, start=1, mode ∈ {001..100}: capture mode and len, no op executed this edge; len≠0 → SHIFT, len=0 → DONE. start with other modes: executes mode as normal, start ignored.
- SHIFT: on each ce=1 edge execute captured op, decrement counter; at count reaching 0 → DONE. mode, len, start, pdin ignored. ce=0 stalls (counter and q held).
- DONE: one cycle, → IDLE unconditionally (ce not required); no op executed; start ignored.
- Reset (rst=0 at active edge): q=0, so=0, busy=0, done=0, counter=0, state IDLE; overrides ce and any burst in progress.

## Timing
- All outputs registered; single-edge latency from input to q/so.
- busy=1 exactly while in SHIFT; rises at edge after start accepted, falls at edge of final op.
- done=1 exactly while in DONE (one clock). len=0: done pulses one cycle after start, busy never asserts, q unchanged.
- Burst of N with ce held high: busy N cycles, done cycle N+1; each ce=0 cycle in SHIFT extends busy by one.
- si sampled on every executed op edge during burst.
- Counter range 0..2^CNT_W−1; len > WIDTH legal (shifts continue, shift modes saturate to si fill).

## Configuration
- SHIFT_NEG_EDGE_EN defined: every flop updates on falling edge of clk; reset sampled on falling edge.
- Undefined: every flop updates on rising edge of clk. Functional behaviour otherwise identical.

## Test plan
- Reset: rst=0 for one active edge with ce=1, mode=101, pdin=0xFF → q=0x00, so=0, busy=0, done=0.
- Load 0xA5 (mode 101), then mode 001, si=1 for 4 edges → q=0xD2,0xE9,0xF4,0xFA; so=1,0,1,0.
- Load 0x81, mode 100 one edge → q=0x03, so=1; ce=0 with mode 001 for 3 edges → q stays 0x03.
- Load 0x0F, start=1 mode=010 len=3 si=0, ce high → busy 3 cycles, q=0x78, so=0, done one cycle after; repeat with ce=0 for 2 cycles mid-burst → busy 5 cycles, same final q.
- start=1 mode=011 len=0 → done pulses next cycle, busy stays 0, q unchanged; start=1 mode=101 → load performed, no burst.
- Burst len=6 from q=0xFF, rst=0 after 2 ops → q=0x00, busy=0, done never pulses, state IDLE; next mode 101 load accepted immediately.
